// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge/center-aligned counter, double-buffered compares.
// Optional per-channel output polarity when PWM_POLARITY_EN is defined.
//
// dir   | meaning
// ------+------------------------------------------
// UP    | counting up (edge mode, or center rising)
// DOWN  | center mode, descending towards 1
module pwm_multi #(
    parameter  int CTR_LEN  = 8,
    parameter  int CHANNELS = 4,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CTR_LEN-1:0]  period,
    input  logic                center_mode,
    input  logic                cmp_wr,
    input  logic [CH_W-1:0]     cmp_ch,
    input  logic [CTR_LEN-1:0]  cmp_data,
`ifdef PWM_POLARITY_EN
    input  logic [CHANNELS-1:0] pol_inv,
`endif
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    localparam logic [CTR_LEN-1:0] ONE = CTR_LEN'(1);

    logic [CTR_LEN-1:0]  cnt;
    logic [CTR_LEN-1:0]  p_act;
    dir_t                dir;
    logic                mode_act;
    logic [CTR_LEN-1:0]  shadow  [CHANNELS];
    logic [CTR_LEN-1:0]  cmp_act [CHANNELS];
    logic [CHANNELS-1:0] pol_act;
    logic [CHANNELS-1:0] pol_nxt;
    logic                boundary;

`ifdef PWM_POLARITY_EN
    assign pol_nxt = pol_inv;
`else
    assign pol_nxt = '0;
`endif

    // Boundary = the edge on which cnt returns to 0 and the buffered values go live.
    always_comb begin
        boundary = 1'b0;
        if (mode_act)
            boundary = ((dir == DOWN) && (cnt == ONE)) || (p_act <= ONE);
        else
            boundary = (cnt == p_act);
    end

    assign period_start = en && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++)
                shadow[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                if (cmp_wr && (int'(cmp_ch) == i))
                    shadow[i] <= cmp_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            dir      <= UP;
            p_act    <= '0;
            mode_act <= 1'b0;
            pol_act  <= '0;
            pwm_out  <= '0;
            for (int i = 0; i < CHANNELS; i++)
                cmp_act[i] <= '0;
        end else if (!en) begin
            // Idle: hold at the start of a period and keep tracking the buffers.
            cnt      <= '0;
            dir      <= UP;
            p_act    <= period;
            mode_act <= center_mode;
            pol_act  <= pol_nxt;
            pwm_out  <= pol_act;
            for (int i = 0; i < CHANNELS; i++)
                cmp_act[i] <= shadow[i];
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                pwm_out[i] <= (cnt < cmp_act[i]) ^ pol_act[i];

            if (boundary) begin
                cnt      <= '0;
                dir      <= UP;
                p_act    <= period;
                mode_act <= center_mode;
                pol_act  <= pol_nxt;
                for (int i = 0; i < CHANNELS; i++)
                    cmp_act[i] <= shadow[i];
            end else if (!mode_act) begin
                cnt <= cnt + 1'b1;
            end else if (dir == UP) begin
                if (cnt == p_act) begin
                    dir <= DOWN;
                    cnt <= cnt - 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus randomized traffic
// against a period-sequence reference model.
module tb_pwm_multi;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] period;
    logic       center_mode;
    logic       cmp_wr;
    logic [1:0] cmp_ch;
    logic [7:0] cmp_data;
    logic [3:0] pol_inv;
    logic [3:0] pwm_out;
    logic       period_start;

    logic       cmp_wr2;
    logic [2:0] cmp_ch2;
    logic [4:0] pwm_out5;
    logic       ps5;

    int checks   = 0;
    int failures = 0;

    pwm_multi u_dut (
        .clk(clk), .rst(rst), .en(en), .period(period), .center_mode(center_mode),
        .cmp_wr(cmp_wr), .cmp_ch(cmp_ch), .cmp_data(cmp_data),
`ifdef PWM_POLARITY_EN
        .pol_inv(pol_inv),
`endif
        .pwm_out(pwm_out), .period_start(period_start)
    );

    pwm_multi #(.CHANNELS(5)) u_dut5 (
        .clk(clk), .rst(rst), .en(en), .period(period), .center_mode(center_mode),
        .cmp_wr(cmp_wr2), .cmp_ch(cmp_ch2), .cmp_data(cmp_data),
`ifdef PWM_POLARITY_EN
        .pol_inv(5'b0),
`endif
        .pwm_out(pwm_out5), .period_start(ps5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a period is the list of counter values it will visit.
    int         m_seq[$];
    int         m_act[4];
    int         m_sh[4];
    logic [3:0] m_pwm;
    logic [3:0] m_pol;

    function automatic void gen_seq(int p, bit c);
        m_seq.delete();
        if (c && p <= 1) begin
            m_seq.push_back(0);
        end else begin
            for (int k = 0; k <= p; k++) m_seq.push_back(k);
            if (c) for (int k = p - 1; k >= 1; k--) m_seq.push_back(k);
        end
    endfunction

    function automatic void model_reset();
        m_seq.delete();
        m_seq.push_back(0);
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0;
            m_sh[i]  = 0;
        end
        m_pwm = '0;
        m_pol = '0;
    endfunction

    function automatic void model_edge();
        logic [3:0] pol_in;
        int cur;
`ifdef PWM_POLARITY_EN
        pol_in = pol_inv;
`else
        pol_in = '0;
`endif
        if (!en) begin
            m_pwm = m_pol;
            m_pol = pol_in;
            for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
            gen_seq(int'(period), center_mode);
        end else begin
            cur = m_seq[0];
            for (int i = 0; i < 4; i++) m_pwm[i] = (cur < m_act[i]) ^ m_pol[i];
            void'(m_seq.pop_front());
            if (m_seq.size() == 0) begin
                for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
                m_pol = pol_in;
                gen_seq(int'(period), center_mode);
            end
        end
        if (cmp_wr) m_sh[cmp_ch] = int'(cmp_data);
    endfunction

    function automatic logic exp_ps();
        return en && (m_seq[0] == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(int ch, int d);
        cmp_wr   = 1'b1;
        cmp_ch   = 2'(ch);
        cmp_data = 8'(d);
        step();
        cmp_wr   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pwm_out !== 4'b0) begin failures++; $display("FAIL reset_pwm got=%b exp=0000", pwm_out); end
        checks++; if (period_start !== 1'b0) begin failures++; $display("FAIL reset_ps got=%b exp=0", period_start); end
        checks++; if (pwm_out5 !== 5'b0) begin failures++; $display("FAIL reset_pwm5 got=%b exp=00000", pwm_out5); end
        rst = 1'b1;
    endtask

    task automatic test_edge();
        int hi[4];
        int ps;
        en = 1'b0; period = 8'd9; center_mode = 1'b0;
        wr(0, 3); wr(1, 0); wr(2, 10); wr(3, 12);
        step();
        en = 1'b1;
        for (int i = 0; i < 4; i++) hi[i] = 0;
        ps = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            checks++; if (pwm_out !== m_pwm) begin failures++; $display("FAIL edge_pwm cyc=%0d got=%b exp=%b", c, pwm_out, m_pwm); end
            checks++; if (period_start !== exp_ps()) begin failures++; $display("FAIL edge_ps cyc=%0d got=%b exp=%b", c, period_start, exp_ps()); end
            if (c >= 2 && c < 12) begin
                for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
                ps += int'(period_start);
            end
        end
        checks++; if (hi[0] != 3) begin failures++; $display("FAIL edge_hi0 got=%0d exp=3", hi[0]); end
        checks++; if (hi[1] != 0) begin failures++; $display("FAIL edge_hi1 got=%0d exp=0", hi[1]); end
        checks++; if (hi[2] != 10) begin failures++; $display("FAIL edge_hi2 got=%0d exp=10", hi[2]); end
        checks++; if (hi[3] != 10) begin failures++; $display("FAIL edge_hi3 got=%0d exp=10", hi[3]); end
        checks++; if (ps != 1) begin failures++; $display("FAIL edge_ps_count got=%0d exp=1", ps); end
    endtask

    task automatic test_center();
        int hi;
        int ps;
        period = 8'd8; center_mode = 1'b1;
        wr(0, 4);
        hi = 0; ps = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            checks++; if (pwm_out !== m_pwm) begin failures++; $display("FAIL center_pwm cyc=%0d got=%b exp=%b", c, pwm_out, m_pwm); end
            checks++; if (period_start !== exp_ps()) begin failures++; $display("FAIL center_ps cyc=%0d got=%b exp=%b", c, period_start, exp_ps()); end
            if (c >= 30 && c < 46) begin
                hi += int'(pwm_out[0]);
                ps += int'(period_start);
            end
        end
        checks++; if (hi != 7) begin failures++; $display("FAIL center_hi0 got=%0d exp=7", hi); end
        checks++; if (ps != 1) begin failures++; $display("FAIL center_ps_count got=%0d exp=1", ps); end
    endtask

    task automatic test_mid_write();
        int hi;
        int n;
        period = 8'd9; center_mode = 1'b0;
        wr(0, 3);
        for (int c = 0; c < 30; c++) step();
        n = 0;
        while (m_seq[0] != 4 && n < 30) begin step(); n++; end
        checks++; if (n >= 30) begin failures++; $display("FAIL mid_wait got=timeout exp=cnt4"); end
        wr(0, 5);
        hi = int'(pwm_out[0]);
        n = 0;
        while (m_seq[0] != 0 && n < 30) begin step(); hi += int'(pwm_out[0]); n++; end
        checks++; if (hi != 0) begin failures++; $display("FAIL mid_old_duty got=%0d exp=0", hi); end
        hi = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            hi += int'(pwm_out[0]);
            checks++; if (pwm_out !== m_pwm) begin failures++; $display("FAIL mid_pwm cyc=%0d got=%b exp=%b", c, pwm_out, m_pwm); end
        end
        checks++; if (hi != 5) begin failures++; $display("FAIL mid_new_duty got=%0d exp=5", hi); end
    endtask

    task automatic test_boundary_write();
        int hi;
        int n;
        n = 0;
        while (m_seq[0] != 9 && n < 30) begin step(); n++; end
        checks++; if (n >= 30) begin failures++; $display("FAIL bnd_wait got=timeout exp=cntP"); end
        wr(0, 2);
        hi = 0;
        for (int c = 0; c < 10; c++) begin step(); hi += int'(pwm_out[0]); end
        checks++; if (hi != 5) begin failures++; $display("FAIL bnd_old got=%0d exp=5", hi); end
        hi = 0;
        for (int c = 0; c < 10; c++) begin step(); hi += int'(pwm_out[0]); end
        checks++; if (hi != 2) begin failures++; $display("FAIL bnd_new got=%0d exp=2", hi); end
    endtask

    task automatic test_p0();
        period = 8'd0;
        for (int c = 0; c < 15; c++) begin
            step();
            checks++; if (pwm_out !== m_pwm) begin failures++; $display("FAIL p0_pwm cyc=%0d got=%b exp=%b", c, pwm_out, m_pwm); end
            if (c >= 10) begin
                checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL p0_ps cyc=%0d got=%b exp=1", c, period_start); end
                checks++; if (pwm_out !== 4'b1101) begin failures++; $display("FAIL p0_level cyc=%0d got=%b exp=1101", c, pwm_out); end
            end
        end
    endtask

    task automatic test_bad_ch();
        cmp_data = 8'hFF;
        for (int ch = 5; ch < 8; ch++) begin
            cmp_wr2 = 1'b1; cmp_ch2 = 3'(ch);
            step();
        end
        cmp_wr2 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++; if (pwm_out5 !== 5'b0) begin failures++; $display("FAIL badch_pwm cyc=%0d got=%b exp=00000", c, pwm_out5); end
            checks++; if (ps5 !== exp_ps()) begin failures++; $display("FAIL badch_ps cyc=%0d got=%b exp=%b", c, ps5, exp_ps()); end
        end
        cmp_wr2 = 1'b1; cmp_ch2 = 3'd4; cmp_data = 8'd1;
        step();
        cmp_wr2 = 1'b0;
        repeat (3) step();
        checks++; if (pwm_out5 !== 5'b10000) begin failures++; $display("FAIL ch4_write got=%b exp=10000", pwm_out5); end
    endtask

`ifdef PWM_POLARITY_EN
    task automatic test_polarity();
        en = 1'b0; pol_inv = 4'b0001;
        repeat (3) step();
        checks++; if (pwm_out !== 4'b0001) begin failures++; $display("FAIL pol_idle got=%b exp=0001", pwm_out); end
        pol_inv = 4'b0000;
        repeat (3) step();
        checks++; if (pwm_out !== 4'b0000) begin failures++; $display("FAIL pol_clear got=%b exp=0000", pwm_out); end
        en = 1'b1;
    endtask
`endif

    task automatic test_random();
        en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            if ($urandom_range(0, 99) < 8) begin
                period      = 8'($urandom_range(0, 12));
                center_mode = 1'($urandom_range(0, 1));
            end
`ifdef PWM_POLARITY_EN
            if ($urandom_range(0, 99) < 4) pol_inv = 4'($urandom_range(0, 15));
`endif
            cmp_wr   = ($urandom_range(0, 3) == 0);
            cmp_ch   = 2'($urandom_range(0, 3));
            cmp_data = 8'($urandom_range(0, 14));
            step();
            cmp_wr = 1'b0;
            checks++; if (pwm_out !== m_pwm) begin failures++; $display("FAIL rand_pwm cyc=%0d got=%b exp=%b", c, pwm_out, m_pwm); end
            checks++; if (period_start !== exp_ps()) begin failures++; $display("FAIL rand_ps cyc=%0d got=%b exp=%b", c, period_start, exp_ps()); end
        end
    endtask

    task automatic test_rst_mid();
        en = 1'b1; period = 8'd9; center_mode = 1'b0;
`ifdef PWM_POLARITY_EN
        pol_inv = 4'b0000;
`endif
        wr(0, 6); wr(1, 9);
        repeat (15) step();
        rst = 1'b0;
        #1;
        checks++; if (pwm_out !== 4'b0) begin failures++; $display("FAIL rst_pwm got=%b exp=0000", pwm_out); end
        checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL rst_cnt0 got=%b exp=1", period_start); end
        checks++; if (pwm_out5 !== 5'b0) begin failures++; $display("FAIL rst_pwm5 got=%b exp=00000", pwm_out5); end
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (pwm_out !== 4'b0) begin failures++; $display("FAIL rst_hold got=%b exp=0000", pwm_out); end
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            checks++; if (pwm_out !== m_pwm) begin failures++; $display("FAIL post_rst_pwm cyc=%0d got=%b exp=%b", c, pwm_out, m_pwm); end
            checks++; if (period_start !== exp_ps()) begin failures++; $display("FAIL post_rst_ps cyc=%0d got=%b exp=%b", c, period_start, exp_ps()); end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; period = '0; center_mode = 1'b0;
        cmp_wr = 1'b0; cmp_ch = '0; cmp_data = '0; pol_inv = '0;
        cmp_wr2 = 1'b0; cmp_ch2 = '0;
        model_reset();
        test_reset();
        test_edge();
        test_center();
        test_mid_write();
        test_boundary_write();
        test_p0();
        test_bad_ch();
`ifdef PWM_POLARITY_EN
        test_polarity();
`endif
        test_random();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
